// File: rtl/rv6_mem_pkg.sv
// Shared definitions for the instruction-side memory refill path.
// Contents:
//   state_t     - refill FSM states (PF_* are only reached when the
//                 IMEM_FILL_PREFETCH_EN build option is enabled)
//   LINE_BITS   - cache line width in bits
//   BEAT_BITS   - memory beat width in bits
//   LINE_OFF_W  - byte-offset width inside one line
//   LINE_BYTES  - bytes per line
//   line_align  - clears the byte offset of an address
package rv6_mem_pkg;

    localparam int LINE_BITS  = 1024;
    localparam int BEAT_BITS  = 64;
    localparam int LINE_BYTES = LINE_BITS / 8;
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DLVR,
        PF_REQ,
        PF_FILL
    } state_t;

    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return {addr[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/imem_fill_lbuf.sv
// Beat-indexed line assembler. Each accepted beat is written at the slot
// selected by the beat counter; beat 0 lands in the least significant
// bits, so the line is little-endian by byte.
// Ports:
//   clk, clr - clock and synchronous active-high reset
//   start    - restart the beat counter for a new burst
//   wr       - write data into the current slot and advance
//   data     - beat data
//   line     - assembled line (registered)
//   last     - high when the current write fills the final slot
module imem_fill_lbuf #(
    parameter int  LINE_BITS = 1024,
    parameter int  BEAT_BITS = 64,
    localparam int BEATS     = LINE_BITS / BEAT_BITS,
    localparam int CNT_W     = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 wr,
    input  logic [BEAT_BITS-1:0] data,
    output logic [LINE_BITS-1:0] line,
    output logic                 last
);
    import rv6_mem_pkg::*;

    logic [CNT_W-1:0] cnt;

    // The counter is compared against the final slot and never wraps
    // through arithmetic overflow; it is returned to zero explicitly.
    assign last = wr && (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= '0;
            line <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (wr) begin
            line[int'(cnt) * BEAT_BITS +: BEAT_BITS] <= data;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_fill.sv
// Instruction cache line-refill engine. A level miss request (b_rd)
// fetches the 128-byte line holding pc as a burst of 64-bit beats and
// returns the assembled line with a one-cycle b_dv strobe.
// If the fetch address leaves the requested line (or b_rd drops) while a
// burst is outstanding, the burst is drained and the line is discarded.
// Build option IMEM_FILL_PREFETCH_EN: after each delivery, the next line
// is fetched into a separate prefetch buffer that can satisfy a later miss.
// Ports:
//   clk, clr           - clock and synchronous active-high reset
//   pc, b_rd           - fetch address and cache miss request
//   b_data, b_dv       - returned line and its valid strobe
//   m_addr, m_req      - burst address and request (held until m_gnt)
//   m_gnt              - burst accepted
//   m_data, m_dv       - beat data and beat valid
//   busy               - engine is not idle
module imem_fill #(
    parameter int XLEN      = 64,
    parameter int LINE_BITS = 1024,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [XLEN-1:0]      pc,
    input  logic                 b_rd,
    output logic [LINE_BITS-1:0] b_data,
    output logic                 b_dv,
    output logic [XLEN-1:0]      m_addr,
    output logic                 m_req,
    input  logic                 m_gnt,
    input  logic [BEAT_BITS-1:0] m_data,
    input  logic                 m_dv,
    output logic                 busy
);
    import rv6_mem_pkg::*;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      line_addr_q, line_addr_d;
    logic [XLEN-1:0]      pc_line;
    logic                 stale_q, stale_d;
    logic                 redirect;
    logic                 dem_start, dem_wr, dem_last;
    logic [LINE_BITS-1:0] dem_line;

    assign pc_line  = line_align(pc);
    // The request no longer wants the line being fetched.
    assign redirect = !b_rd || (pc_line != line_addr_q);
    assign dem_wr   = (state_q == FILL) && m_dv;
    assign busy     = (state_q != IDLE);

    imem_fill_lbuf #(
        .LINE_BITS(LINE_BITS),
        .BEAT_BITS(BEAT_BITS)
    ) u_dem_buf (
        .clk  (clk),
        .clr  (clr),
        .start(dem_start),
        .wr   (dem_wr),
        .data (m_data),
        .line (dem_line),
        .last (dem_last)
    );

`ifdef IMEM_FILL_PREFETCH_EN
    logic [XLEN-1:0]      pf_addr_q, pf_addr_d;
    logic                 pf_valid_q, pf_valid_d;
    logic                 src_pf_q, src_pf_d;
    logic                 pf_start, pf_wr, pf_last, pf_match;
    logic [LINE_BITS-1:0] pf_line;

    assign pf_match = b_rd && (pc_line == pf_addr_q);
    assign pf_wr    = (state_q == PF_FILL) && m_dv;

    imem_fill_lbuf #(
        .LINE_BITS(LINE_BITS),
        .BEAT_BITS(BEAT_BITS)
    ) u_pf_buf (
        .clk  (clk),
        .clr  (clr),
        .start(pf_start),
        .wr   (pf_wr),
        .data (m_data),
        .line (pf_line),
        .last (pf_last)
    );

    // Both sources are registers; src_pf_q picks the one being delivered.
    assign b_data = src_pf_q ? pf_line : dem_line;
    assign m_addr = (state_q == PF_REQ || state_q == PF_FILL) ? pf_addr_q : line_addr_q;
`else
    assign b_data = dem_line;
    assign m_addr = line_addr_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            stale_q     <= 1'b0;
`ifdef IMEM_FILL_PREFETCH_EN
            pf_addr_q   <= '0;
            pf_valid_q  <= 1'b0;
            src_pf_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            stale_q     <= stale_d;
`ifdef IMEM_FILL_PREFETCH_EN
            pf_addr_q   <= pf_addr_d;
            pf_valid_q  <= pf_valid_d;
            src_pf_q    <= src_pf_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        stale_d     = stale_q;
        dem_start   = 1'b0;
        m_req       = 1'b0;
        b_dv        = 1'b0;
`ifdef IMEM_FILL_PREFETCH_EN
        pf_addr_d   = pf_addr_q;
        pf_valid_d  = pf_valid_q;
        src_pf_d    = src_pf_q;
        pf_start    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stale_d = 1'b0;
                if (b_rd) begin
`ifdef IMEM_FILL_PREFETCH_EN
                    if (pf_valid_q && (pc_line == pf_addr_q)) begin
                        line_addr_d = pf_addr_q;
                        pf_valid_d  = 1'b0;
                        src_pf_d    = 1'b1;
                        state_d     = DLVR;
                    end else
`endif
                    begin
                        line_addr_d = pc_line;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                m_req   = 1'b1;
                stale_d = stale_q || redirect;
                if (m_gnt) begin
                    dem_start = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // Stale bursts are still drained so the memory side stays in step.
                stale_d = stale_q || redirect;
                if (dem_last) begin
                    if (stale_q || redirect) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DLVR;
`ifdef IMEM_FILL_PREFETCH_EN
                        src_pf_d = 1'b0;
`endif
                    end
                end
            end
            DLVR: begin
                b_dv = 1'b1;
`ifdef IMEM_FILL_PREFETCH_EN
                pf_addr_d  = line_addr_q + XLEN'(LINE_BYTES);
                pf_valid_d = 1'b0;
                state_d    = PF_REQ;
`else
                state_d    = IDLE;
`endif
            end
`ifdef IMEM_FILL_PREFETCH_EN
            PF_REQ: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    pf_start = 1'b1;
                    state_d  = PF_FILL;
                end
            end
            PF_FILL: begin
                // A miss arriving mid-prefetch is resolved only once the burst drains.
                if (pf_last) begin
                    if (pf_match) begin
                        line_addr_d = pf_addr_q;
                        src_pf_d    = 1'b1;
                        pf_valid_d  = 1'b0;
                        state_d     = DLVR;
                    end else if (b_rd) begin
                        line_addr_d = pc_line;
                        pf_valid_d  = 1'b0;
                        state_d     = REQ;
                    end else begin
                        pf_valid_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_fill.sv
// Self-checking bench for imem_fill: directed steps, a memory responder
// with configurable grant delay / beat gaps, and scoreboards for burst
// addresses and delivered lines.
module tb_imem_fill;

    logic          clk = 1'b0;
    logic          clr, b_rd, b_dv, m_req, m_gnt, m_dv, busy;
    logic [63:0]   pc, m_addr, m_data;
    logic [1023:0] b_data;

    imem_fill dut (
        .clk   (clk),
        .clr   (clr),
        .pc    (pc),
        .b_rd  (b_rd),
        .b_data(b_data),
        .b_dv  (b_dv),
        .m_addr(m_addr),
        .m_req (m_req),
        .m_gnt (m_gnt),
        .m_data(m_data),
        .m_dv  (m_dv),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [1023:0] exp_q[$];
    logic [63:0]   exp_addr_q[$];

    // memory responder controls / statistics
    int          gnt_delay = 0;
    bit          gaps = 0;
    bit          extra_beat = 0;
    bit          spur_idle = 0;
    logic [63:0] beat_base = 64'h0;
    int          n_bursts = 0;
    int          beats_sent = 0;
    int          n_beats_total = 0;

    // monitor statistics
    int n_dv = 0;
    int dv_cyc = 0;
    int dv_bursts = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int idx;
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            idx = 0;
            for (int i = 15; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) idx = i;
            $error("FAIL %s: beat %0d observed %h expected %h", tag, idx,
                   obs[64*idx +: 64], exp[64*idx +: 64]);
        end
    endtask

    function automatic logic [63:0] beat_val(input logic [63:0] addr, input int i, input logic [63:0] base);
        return base + {40'b0, addr[15:0], 8'h00} + 64'(i);
    endfunction

    function automatic logic [1023:0] line_val(input logic [63:0] addr, input logic [63:0] base);
        logic [1023:0] l;
        for (int i = 0; i < 16; i++) l[64*i +: 64] = beat_val(addr, i, base);
        return l;
    endfunction

    // ---------------- memory responder ----------------
    task automatic serve_burst();
        logic [63:0] a;
        a = m_addr;
        for (int k = 0; k < gnt_delay; k++) begin
            check("m_req_held", {63'b0, m_req}, 64'd1);
            check("m_addr_steady", m_addr, a);
            @(negedge clk);
        end
        m_gnt = 1'b1;
        n_bursts++;
        beats_sent = 0;
        check("addr_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) check("burst_addr", a, exp_addr_q.pop_front());
        @(negedge clk);
        m_gnt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (clr) begin
                m_dv = 1'b0;
                return;
            end
            m_dv = 1'b1;
            m_data = beat_val(a, i, beat_base);
            @(negedge clk);
            beats_sent = i + 1;
            n_beats_total++;
            if (gaps) begin
                m_dv = 1'b0;
                @(negedge clk);
            end
        end
        m_dv = 1'b0;
        if (extra_beat) begin
            m_dv = 1'b1;
            m_data = 64'hdead_beef_dead_beef;
            @(negedge clk);
            m_dv = 1'b0;
        end
    endtask

    initial begin
        m_gnt = 1'b0;
        m_dv = 1'b0;
        m_data = '0;
        forever begin
            @(negedge clk);
            if (m_req && !clr) begin
                serve_burst();
            end else if (spur_idle) begin
                spur_idle = 0;
                m_dv = 1'b1;
                m_data = 64'h0bad_f00d_0bad_f00d;
                @(negedge clk);
                m_dv = 1'b0;
            end
        end
    end

    // ---------------- line monitor / scoreboard ----------------
    initial begin
        logic prev_dv;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (b_dv === 1'b1) begin
                check("b_dv_width", {63'b0, prev_dv}, 64'd0);
                check("dv_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check_line("b_data", b_data, exp_q.pop_front());
                n_dv++;
                dv_cyc = cyc;
                dv_bursts = n_bursts;
            end
            prev_dv = b_dv;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dv(input int n0, input int budget, input string tag);
        int k = 0;
        while (n_dv == n0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(n_dv != n0), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {63'b0, busy}, 64'd0);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (beats_sent != n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(beats_sent), 64'(n));
    endtask

    // expected extra prefetch bursts after each delivery
`ifdef IMEM_FILL_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    task automatic push_pf(input logic [63:0] line_addr);
`ifdef IMEM_FILL_PREFETCH_EN
        exp_addr_q.push_back(line_addr + 64'd128);
`else
        if (line_addr == 64'h1) $display("unused %h", line_addr);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n0, nb0, c0, bt0;
        clr = 1'b1;
        b_rd = 1'b0;
        pc = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b_dv", {63'b0, b_dv}, 64'd0);
        check("rst_m_req", {63'b0, m_req}, 64'd0);
        check("rst_m_addr", m_addr, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check_line("rst_b_data", b_data, '0);
        tick(1);
        clr = 1'b0;
        tick(1);

        // basic refill, zero-wait memory
        beat_base = 64'h1000;
        pc = 64'h8000_0044;
        exp_addr_q.push_back(64'h8000_0000);
        push_pf(64'h8000_0000);
        exp_q.push_back(line_val(64'h8000_0000, 64'h1000));
        n0 = n_dv; nb0 = n_bursts; c0 = cyc;
        b_rd = 1'b1;
        wait_dv(n0, 100, "t1_dv_timeout");
        b_rd = 1'b0;
        check("t1_latency", 64'(dv_cyc - c0), 64'd18);
        wait_idle(200, "t1_idle");
        check("t1_bursts", 64'(n_bursts - nb0), 64'(1 + PF));

        // grant stall and beat gaps
        gnt_delay = 3; gaps = 1;
        beat_base = 64'h2000;
        pc = 64'h8000_2010;
        exp_addr_q.push_back(64'h8000_2000);
        push_pf(64'h8000_2000);
        exp_q.push_back(line_val(64'h8000_2000, 64'h2000));
        n0 = n_dv; nb0 = n_bursts; c0 = cyc;
        b_rd = 1'b1;
        wait_dv(n0, 200, "t2_dv_timeout");
        b_rd = 1'b0;
        check("t2_latency", 64'(dv_cyc - c0), 64'd36);
        wait_idle(300, "t2_idle");
        check("t2_bursts", 64'(n_bursts - nb0), 64'(1 + PF));
        gnt_delay = 0; gaps = 0;

        // redirect mid-fill: stale line drained and dropped, new line fetched
        beat_base = 64'h3000;
        pc = 64'h8000_0300;
        exp_addr_q.push_back(64'h8000_0300);
        exp_addr_q.push_back(64'h8000_1000);
        push_pf(64'h8000_1000);
        exp_q.push_back(line_val(64'h8000_1000, 64'h3000));
        n0 = n_dv; nb0 = n_bursts; bt0 = n_beats_total;
        b_rd = 1'b1;
        wait_beats(6, 100, "t3_beats");
        pc = 64'h8000_1000;
        wait_dv(n0, 200, "t3_dv_timeout");
        b_rd = 1'b0;
        wait_idle(200, "t3_idle");
        check("t3_deliveries", 64'(n_dv - n0), 64'd1);
        check("t3_bursts", 64'(n_bursts - nb0), 64'(2 + PF));
        check("t3_beats_drained", 64'(n_beats_total - bt0), 64'(32 + 16 * PF));

        // reset mid-fill, then a clean refill
        beat_base = 64'h4000;
        pc = 64'h8000_4000;
        exp_addr_q.push_back(64'h8000_4000);
        n0 = n_dv;
        b_rd = 1'b1;
        wait_beats(8, 100, "t4_beats");
        b_rd = 1'b0;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        check("t4_m_req", {63'b0, m_req}, 64'd0);
        check("t4_b_dv", {63'b0, b_dv}, 64'd0);
        check("t4_busy", {63'b0, busy}, 64'd0);
        tick(2);
        beat_base = 64'h4400;
        pc = 64'h8000_4008;
        exp_addr_q.push_back(64'h8000_4000);
        push_pf(64'h8000_4000);
        exp_q.push_back(line_val(64'h8000_4000, 64'h4400));
        c0 = cyc;
        b_rd = 1'b1;
        wait_dv(n0, 100, "t4_dv_timeout");
        b_rd = 1'b0;
        check("t4_latency", 64'(dv_cyc - c0), 64'd18);
        wait_idle(200, "t4_idle");

        // spurious beat in IDLE, then a 17th beat after a refill
        n0 = n_dv;
        spur_idle = 1;
        tick(4);
        check("t5_idle_busy", {63'b0, busy}, 64'd0);
        check("t5_idle_m_req", {63'b0, m_req}, 64'd0);
        check("t5_idle_no_dv", 64'(n_dv - n0), 64'd0);
        extra_beat = 1;
        beat_base = 64'h5000;
        pc = 64'h8000_5000;
        exp_addr_q.push_back(64'h8000_5000);
        push_pf(64'h8000_5000);
        exp_q.push_back(line_val(64'h8000_5000, 64'h5000));
        b_rd = 1'b1;
        wait_dv(n0, 100, "t5_dv_timeout");
        b_rd = 1'b0;
        wait_idle(200, "t5_idle");
        extra_beat = 0;
        tick(4);
        check("t5_one_delivery", 64'(n_dv - n0), 64'd1);
        check("t5_busy", {63'b0, busy}, 64'd0);

`ifdef IMEM_FILL_PREFETCH_EN
        // prefetch hit: delivered one cycle after b_rd with no demand burst
        beat_base = 64'h6000;
        pc = 64'h8000_0000;
        exp_addr_q.push_back(64'h8000_0000);
        exp_addr_q.push_back(64'h8000_0080);
        exp_q.push_back(line_val(64'h8000_0000, 64'h6000));
        n0 = n_dv;
        b_rd = 1'b1;
        wait_dv(n0, 100, "t6_dv_timeout");
        b_rd = 1'b0;
        wait_idle(200, "t6_idle");
        pc = 64'h8000_0080;
        exp_addr_q.push_back(64'h8000_0100);
        exp_q.push_back(line_val(64'h8000_0080, 64'h6000));
        n0 = n_dv; nb0 = n_bursts; c0 = cyc;
        b_rd = 1'b1;
        wait_dv(n0, 100, "t6_hit_timeout");
        b_rd = 1'b0;
        check("t6_hit_latency", 64'(dv_cyc - c0), 64'd1);
        check("t6_hit_no_burst", 64'(dv_bursts - nb0), 64'd0);
        wait_idle(200, "t6_hit_idle");
        // buffer was consumed: the same line now needs a demand burst
        exp_addr_q.push_back(64'h8000_0080);
        exp_addr_q.push_back(64'h8000_0100);
        exp_q.push_back(line_val(64'h8000_0080, 64'h6000));
        n0 = n_dv; c0 = cyc;
        b_rd = 1'b1;
        wait_dv(n0, 100, "t6_miss_timeout");
        b_rd = 1'b0;
        check("t6_miss_latency", 64'(dv_cyc - c0), 64'd18);
        wait_idle(200, "t6_miss_idle");
`endif

        tick(3);
        check("lines_left", 64'(exp_q.size()), 64'd0);
        check("addrs_left", 64'(exp_addr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
